// File: rtl/mem_access_unit_if.sv
// Memory-side bus of mem_access_unit: request/ack handshake with a
// variable-latency unified memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_req;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_req,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_req,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit for a multicycle CPU: turns control-unit strobes into a
// req/ack memory transaction and holds IR/MDR. Optional: MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                ior_d,
  input  logic                ir_write,
  input  logic [ADDR_W-1:0]   pc,
  input  logic [ADDR_W-1:0]   alu_out,
  input  logic [DATA_W-1:0]   write_data,
  mem_access_unit_if.master   mem,
  output logic [DATA_W-1:0]   instr,
  output logic [5:0]          op_code,
  output logic [DATA_W-1:0]   mdr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_req_q, mem_req_d;
  logic              ir_wr_q, ir_wr_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              req_s;
  logic              misalign_s;
  logic              timeout_s;
  logic              busy_s;
  logic [ADDR_W-1:0] sel_addr_s;

  // Request decode, address select and optional alignment check
  always_comb begin
    req_s      = mem_read | mem_write;
    sel_addr_s = ior_d ? alu_out : pc;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_s = (sel_addr_s[1:0] != 2'b00);
`else
    misalign_s = 1'b0;
`endif
    timeout_s  = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_req_d   = mem_req_q;
    ir_wr_d     = ir_wr_q;
    wait_cnt_d  = wait_cnt_q;
    instr_d     = instr_q;
    mdr_d       = mdr_q;
    done_d      = 1'b0;
    err_d       = err_q;
    busy_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          // Busy is raised combinationally so the control FSM stalls now
          busy_s = 1'b1;
          if (misalign_s) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d     = S_REQ;
            mem_addr_d  = sel_addr_s;
            mem_wdata_d = write_data;
            mem_we_d    = mem_write;
            ir_wr_d     = ir_write & ~mem_write;
            mem_req_d   = 1'b1;
            wait_cnt_d  = {CNT_W{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        busy_s = 1'b1;
        if (mem.mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          if (!mem_we_q) begin
            mdr_d = mem.mem_rdata;
            if (ir_wr_q) begin
              instr_d = mem.mem_rdata;
            end else begin
              instr_d = instr_q;
            end
          end else begin
            mdr_d = mdr_q;
          end
        end else if (timeout_s) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          done_d    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and register bank; reset abandons any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      ir_wr_q     <= 1'b0;
      wait_cnt_q  <= {CNT_W{1'b0}};
      instr_q     <= {DATA_W{1'b0}};
      mdr_q       <= {DATA_W{1'b0}};
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_req_q   <= mem_req_d;
      ir_wr_q     <= ir_wr_d;
      wait_cnt_q  <= wait_cnt_d;
      instr_q     <= instr_d;
      mdr_q       <= mdr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_req   = mem_req_q;
  assign instr         = instr_q;
  assign op_code       = instr_q[DATA_W-1 -: 6];
  assign mdr           = mdr_q;
  assign busy          = busy_s;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT = 4).
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        mem_read, mem_write, ior_d, ir_write;
  logic [31:0] pc, alu_out, write_data;
  logic [31:0] instr, mdr;
  logic [5:0]  op_code;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;
  int req_cnt;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ior_d      (ior_d),
    .ir_write   (ir_write),
    .pc         (pc),
    .alu_out    (alu_out),
    .write_data (write_data),
    .mem        (mem_if),
    .instr      (instr),
    .op_code    (op_code),
    .mdr        (mdr),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; ior_d = 1'b0; ir_write = 1'b0;
    pc = 32'h0; alu_out = 32'h0; write_data = 32'h0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
    #3;
    chk("rst_req",   64'(mem_if.mem_req),  64'h0);
    chk("rst_we",    64'(mem_if.mem_we),   64'h0);
    chk("rst_addr",  64'(mem_if.mem_addr), 64'h0);
    chk("rst_wdata", 64'(mem_if.mem_wdata), 64'h0);
    chk("rst_busy",  64'(busy),    64'h0);
    chk("rst_done",  64'(done),    64'h0);
    chk("rst_err",   64'(err),     64'h0);
    chk("rst_instr", 64'(instr),   64'h0);
    chk("rst_op",    64'(op_code), 64'h0);
    chk("rst_mdr",   64'(mdr),     64'h0);
    cyc();
    reset = 1'b1;

    // Fetch: ack during the third REQ cycle -> busy for 4 cycles
    cyc();
    pc = 32'h0000_0010; mem_read = 1'b1; ir_write = 1'b1; ior_d = 1'b0;
    #1;
    busy_cnt = 0;
    chk("fetch_busy_idle", 64'(busy), 64'h1);
    chk("fetch_noreq_idle", 64'(mem_if.mem_req), 64'h0);
    if (busy) busy_cnt++;
    cyc();
    mem_read = 1'b0; ir_write = 1'b0; pc = 32'h0000_0FF0;
    chk("fetch_req", 64'(mem_if.mem_req), 64'h1);
    chk("fetch_addr", 64'(mem_if.mem_addr), 64'h10);
    chk("fetch_we", 64'(mem_if.mem_we), 64'h0);
    if (busy) busy_cnt++;
    cyc();
    if (busy) busy_cnt++;
    cyc();
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h2008_0005;
    if (busy) busy_cnt++;
    cyc();
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
    if (busy) busy_cnt++;
    chk("fetch_busy_cycles", 64'(busy_cnt), 64'd4);
    chk("fetch_done", 64'(done), 64'h1);
    chk("fetch_req_drop", 64'(mem_if.mem_req), 64'h0);
    chk("fetch_instr", 64'(instr), 64'h2008_0005);
    chk("fetch_op", 64'(op_code), 64'h08);
    chk("fetch_mdr", 64'(mdr), 64'h2008_0005);
    cyc();
    chk("fetch_done_pulse", 64'(done), 64'h0);

    // Load, zero-wait: done exactly 2 edges after the request
    ior_d = 1'b1; alu_out = 32'h40; mem_read = 1'b1; ir_write = 1'b0;
    cyc();
    mem_read = 1'b0;
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hDEAD_BEEF;
    chk("load_addr", 64'(mem_if.mem_addr), 64'h40);
    chk("load_done_early", 64'(done), 64'h0);
    cyc();
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
    chk("load_done", 64'(done), 64'h1);
    chk("load_mdr", 64'(mdr), 64'hDEAD_BEEF);
    chk("load_instr_keep", 64'(instr), 64'h2008_0005);
    cyc();

    // Store with simultaneous read: write wins, inputs change mid-REQ
    mem_write = 1'b1; mem_read = 1'b1; ior_d = 1'b1; alu_out = 32'h44;
    write_data = 32'h1234_5678; ir_write = 1'b1;
    cyc();
    mem_write = 1'b0; mem_read = 1'b0; write_data = 32'hFFFF_FFFF; alu_out = 32'h0;
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hCAFE_F00D;
    chk("store_we", 64'(mem_if.mem_we), 64'h1);
    chk("store_wdata", 64'(mem_if.mem_wdata), 64'h1234_5678);
    chk("store_addr", 64'(mem_if.mem_addr), 64'h44);
    cyc();
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
    chk("store_done", 64'(done), 64'h1);
    chk("store_mdr_keep", 64'(mdr), 64'hDEAD_BEEF);
    chk("store_instr_keep", 64'(instr), 64'h2008_0005);
    chk("store_err", 64'(err), 64'h0);
    cyc();

    // Stray ack in IDLE is ignored
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h1111_1111;
    cyc();
    mem_if.mem_ack = 1'b0;
    chk("idle_ack_req", 64'(mem_if.mem_req), 64'h0);
    chk("idle_ack_done", 64'(done), 64'h0);
    chk("idle_ack_mdr", 64'(mdr), 64'hDEAD_BEEF);

    // Timeout, no ack: mem_req high exactly 4 cycles
    ior_d = 1'b0; pc = 32'h80; mem_read = 1'b1;
    cyc();
    mem_read = 1'b0;
    req_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_if.mem_req) req_cnt++;
      if (i == 4) begin
        chk("to_done", 64'(done), 64'h1);
        chk("to_err", 64'(err), 64'h1);
        chk("to_mdr_keep", 64'(mdr), 64'hDEAD_BEEF);
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h2222_2222;
      end
      if (i == 5) mem_if.mem_ack = 1'b0;
      cyc();
    end
    mem_if.mem_ack = 1'b0;
    chk("to_req_cycles", 64'(req_cnt), 64'd4);
    chk("to_late_ack_mdr", 64'(mdr), 64'hDEAD_BEEF);
    chk("to_late_ack_req", 64'(mem_if.mem_req), 64'h0);
    chk("to_err_sticky", 64'(err), 64'h1);
    chk("to_idle_done", 64'(done), 64'h0);

    // Async reset in the middle of REQ
    pc = 32'h20; mem_read = 1'b1; ir_write = 1'b1;
    cyc();
    chk("ar_req", 64'(mem_if.mem_req), 64'h1);
    #1;
    reset = 1'b0;
    #1;
    mem_read = 1'b0; ir_write = 1'b0;
    chk("ar_req_drop", 64'(mem_if.mem_req), 64'h0);
    chk("ar_instr", 64'(instr), 64'h0);
    chk("ar_op", 64'(op_code), 64'h0);
    chk("ar_mdr", 64'(mdr), 64'h0);
    chk("ar_err", 64'(err), 64'h0);
    #1;
    reset = 1'b1;
    cyc();
    pc = 32'h30; mem_read = 1'b1; ir_write = 1'b1;
    cyc();
    mem_read = 1'b0; ir_write = 1'b0;
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h8C22_0004;
    chk("ar_fetch_addr", 64'(mem_if.mem_addr), 64'h30);
    cyc();
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
    chk("ar_fetch_done", 64'(done), 64'h1);
    chk("ar_fetch_instr", 64'(instr), 64'h8C22_0004);
    chk("ar_fetch_op", 64'(op_code), 64'h23);
    cyc();

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned load is rejected without a memory request
    reset = 1'b0;
    #1;
    reset = 1'b1;
    ior_d = 1'b1; alu_out = 32'h42; mem_read = 1'b1; ir_write = 1'b0;
    cyc();
    mem_read = 1'b0;
    chk("al_noreq", 64'(mem_if.mem_req), 64'h0);
    chk("al_done", 64'(done), 64'h1);
    chk("al_err", 64'(err), 64'h1);
    chk("al_mdr_keep", 64'(mdr), 64'h0);
    cyc();
    chk("al_idle_done", 64'(done), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the multicycle control unit. Turns its MemRead/MemWrite/IorD/IRWrite strobes into a req/ack transaction on a variable-latency unified memory.
- Holds the Instruction Register (IR) and Memory Data Register (MDR).
- Feeds op_code back to the control unit, plus a busy stall so the control FSM holds its state until the access completes.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, data and instruction width.
- TIMEOUT, 16, max cycles waiting for mem_ack before abort; >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_read  in  1  read request from control unit.
- mem_write  in  1  write request from control unit.
- ior_d  in  1  address select: 0 = pc, 1 = alu_out.
- ir_write  in  1  read data also loads IR.
- pc  in  ADDR_W  program counter.
- alu_out  in  ADDR_W  ALUOut register, data address.
- write_data  in  DATA_W  store data (B register).
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_we  out  1  1 = write transaction.
- mem_req  out  1  request, held until ack or timeout.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- instr  out  DATA_W  Instruction Register.
- op_code  out  6  instr[31:26], combinational.
- mdr  out  DATA_W  Memory Data Register.
- busy  out  1  access in progress; control unit stalls.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, async): state IDLE. mem_req, mem_we, busy, done and err = 0. mem_addr, mem_wdata, instr and mdr = 0, so op_code = 0 (R-type).
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On mem_read|mem_write: capture mem_addr = ior_d ? alu_out : pc, mem_wdata = write_data, mem_we = mem_write, and the ir_write flag. Go to REQ.
  - If mem_read and mem_write are both 1, the write wins and the read is ignored.
  - busy is combinational high in IDLE whenever a request is present, so the control unit stalls in the same cycle.
- REQ:
  - mem_req = 1, busy = 1, and the wait counter increments from 0.
  - mem_ack = 1, read: mdr <= mem_rdata. instr <= mem_rdata only if the latched ir_write = 1. Go to DONE.
  - mem_ack = 1, write: no register update. Go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: mem_req drops, err <= 1, IR and MDR are unchanged, go to DONE.
- DONE: done = 1, busy = 0, mem_req = 0, all requests ignored. Returns to IDLE next cycle.
- Latency: a zero-wait memory (ack in the first REQ cycle) completes in 2 cycles, request edge to done.
- mem_ack outside REQ is ignored. A late ack after a timeout is discarded.
- Inputs that change during REQ have no effect, because all transaction fields are registered in IDLE.
- err is cleared only by reset.
- Reset mid-transaction: mem_req drops immediately (asynchronously). The partial access is abandoned and IR/MDR are cleared.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: in IDLE, a request whose selected address has addr[1:0] != 0 is not issued. The FSM goes straight to DONE (1-cycle done, no mem_req), sets err, and leaves IR/MDR unchanged.
- Undefined: addresses pass through unchecked, and the low bits are driven to memory as given.

Test Plan:
- Fetch: pc=0x0000_0010, mem_read=1, ir_write=1, ack 3 cycles after mem_req, rdata=0x2008_0005 -> mem_addr=0x10, busy for 4 cycles, then done pulse, instr=0x2008_0005, op_code=6'b001000, mdr=0x2008_0005.
- Load: ior_d=1, alu_out=0x40, mem_read=1, ir_write=0, zero-wait ack, rdata=0xDEAD_BEEF -> mdr=0xDEADBEEF, instr unchanged, done exactly 2 cycles after request.
- Store with simultaneous read: mem_write=1, mem_read=1, alu_out=0x44, write_data=0x1234_5678 -> mem_we=1, mem_wdata=0x12345678, mdr unchanged.
- Timeout with TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then err=1, done pulse. A later stray ack is ignored and state returns to IDLE.
- Async reset asserted mid-REQ -> mem_req=0 before the next clk edge, instr=0, op_code=0. After release, a new fetch works normally.
- MEM_ALIGN_CHECK_EN defined, alu_out=0x42 load -> no mem_req, err=1, done one cycle after the request.
